wb_burst_ram_slave: RTL and testbench

- Wishbone B3 registered-feedback responder backed by on-chip RAM.
- Acts as the target end of the same wbsN_* bus the memory-controller wishbone ports present.
- Used as a reference slave and scoreboard-friendly memory model for the bus initiators (wb0/wb1/wb4 traffic generators).
- Supports classic cycles, constant-address bursts and incrementing bursts (linear and wrap-4/8/16), with a programmable number of initial wait states.

---
 rtl/wb_burst_pkg.sv | 41 ++++
 rtl/wb_burst_adr_gen.sv | 17 +
 rtl/wb_burst_ram_slave.sv | 150 +++++++++++++++
 tb/tb_wb_burst_ram_slave.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_pkg.sv
// Shared Wishbone B3 burst definitions: cycle/burst type codes, FSM states
// and the registered-feedback next-address rule used by slaves and initiators.
package wb_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Widest word address the helper handles; callers truncate to their AW.
    localparam int unsigned ADR_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } wb_state_t;

    // Next beat address: linear increments the whole word address, wrap-N
    // holds the upper bits and increments only the low log2(N) bits mod N.
    function automatic logic [ADR_MAX_W-1:0] wb_next_adr(
        input logic [ADR_MAX_W-1:0] adr,
        input logic [1:0]           bte
    );
        logic [ADR_MAX_W-1:0] nxt;
        nxt = adr + 32'd1;
        case (bte)
            BTE_LINEAR: nxt = adr + 32'd1;
            BTE_WRAP4:  nxt = {adr[ADR_MAX_W-1:2], 2'(adr[1:0] + 2'd1)};
            BTE_WRAP8:  nxt = {adr[ADR_MAX_W-1:3], 3'(adr[2:0] + 3'd1)};
            BTE_WRAP16: nxt = {adr[ADR_MAX_W-1:4], 4'(adr[3:0] + 4'd1)};
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Combinational Wishbone burst next-address generator (linear and wrap-4/8/16),
// truncated to the RAM word-address width so linear bursts wrap at the top.
module wb_burst_adr_gen #(
    parameter int unsigned AW = 12
) (
    input  logic [AW-1:0] adr,
    input  logic [1:0]    bte,
    output logic [AW-1:0] next_adr
);
    import wb_burst_pkg::*;

    // Widen, step per burst type, then truncate back to AW bits.
    always_comb begin
        next_adr = AW'(wb_next_adr(ADR_MAX_W'(adr), bte));
    end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 registered-feedback RAM slave: classic, constant-address and
// incrementing bursts with a fixed number of wait states before the first ack.
module wb_burst_ram_slave #(
    parameter int unsigned AW          = 12,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [AW-1:0]   wbs_adr_i,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    input  logic [2:0]      wbs_cti_i,
    input  logic [1:0]      wbs_bte_i,
    input  logic            wbs_we_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    output logic [DW-1:0]   wbs_dat_o,
    output logic            wbs_ack_o
);
    import wb_burst_pkg::*;

    localparam int unsigned SW = DW / 8;

    logic [DW-1:0] mem [2**AW];

    wb_state_t     state;
    logic          ack_q;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] adr_q;     // current beat address, also the predicted next address
    logic          burst_q;   // previous beat was a burst beat, so prediction applies
    logic [AW-1:0] next_adr;
    logic [DW-1:0] merged;    // current word with this beat's write lanes applied
    logic          req;
    logic          miss;
    logic          beat;

    wb_burst_adr_gen #(.AW(AW)) u_adr_gen (
        .adr      (adr_q),
        .bte      (wbs_bte_i),
        .next_adr (next_adr)
    );

    // Ack qualification, prediction check and write-merged word for constant bursts.
    always_comb begin
        req       = wbs_cyc_i & wbs_stb_i;
        wbs_ack_o = ack_q & req;
        miss      = burst_q & ((wbs_adr_i != adr_q) | (wbs_cti_i == CTI_CLASSIC));
        beat      = (state == ST_ACK) & wbs_ack_o & ~miss;
        merged    = mem[adr_q];
        for (int unsigned i = 0; i < SW; i++) begin
            if (wbs_we_i && wbs_sel_i[i]) begin
                merged[8*i +: 8] = wbs_dat_i[8*i +: 8];
            end
        end
    end

    // Byte-lane RAM write on accepted write beats; suppressed while reset is low.
    always_ff @(posedge wb_clk) begin
        if (beat && wbs_we_i && wb_rst_n) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (wbs_sel_i[i]) begin
                    mem[adr_q][8*i +: 8] <= wbs_dat_i[8*i +: 8];
                end
            end
        end
    end

    // Bus FSM with registered ack and read data.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            ack_q     <= 1'b0;
            wbs_dat_o <= '0;
            wait_cnt  <= '0;
            adr_q     <= '0;
            burst_q   <= 1'b0;
        end else if (!wbs_cyc_i) begin
            state   <= ST_IDLE;
            ack_q   <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wbs_stb_i) begin
                        adr_q    <= wbs_adr_i;
                        wait_cnt <= 4'(WAIT_STATES);
                        burst_q  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= ST_ACK;
                            ack_q     <= 1'b1;
                            wbs_dat_o <= mem[wbs_adr_i];
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wbs_stb_i) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt <= 4'd1) begin
                        state     <= ST_ACK;
                        ack_q     <= 1'b1;
                        wait_cnt  <= '0;
                        wbs_dat_o <= mem[adr_q];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (wbs_stb_i) begin
                        if (miss) begin
                            state   <= ST_IDLE;
                            ack_q   <= 1'b0;
                            burst_q <= 1'b0;
                        end else begin
                            case (wbs_cti_i)
                                CTI_CONST: begin
                                    burst_q   <= 1'b1;
                                    wbs_dat_o <= merged;
                                end
                                CTI_INC: begin
                                    burst_q   <= 1'b1;
                                    adr_q     <= next_adr;
                                    wbs_dat_o <= mem[next_adr];
                                end
                                CTI_CLASSIC, CTI_EOB: begin
                                    state   <= ST_IDLE;
                                    ack_q   <= 1'b0;
                                    burst_q <= 1'b0;
                                end
                                default: begin
                                    state   <= ST_IDLE;
                                    ack_q   <= 1'b0;
                                    burst_q <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Self-checking bench for wb_burst_ram_slave: two instances (0 and 3 wait
// states) on a shared bus, a word/byte-level memory model and per-beat checks.
module tb_wb_burst_ram_slave;
    import wb_burst_pkg::*;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          d;
        bit          we;
        logic [AW-1:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic [31:0]   dat_w;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          we, cyc, stb;
    int            dsel;
    logic          cyc0, cyc1, ack0, ack1, ack_m;
    logic [31:0]   dat0, dat1, dat_m;

    int ws [2] = '{0, 3};
    logic [31:0] mmem   [2][DEPTH];
    logic [3:0]  mknown [2][DEPTH];
    int errors = 0;
    int checks = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    assign cyc0  = cyc & (dsel == 0);
    assign cyc1  = cyc & (dsel == 1);
    assign ack_m = (dsel == 1) ? ack1 : ack0;
    assign dat_m = (dsel == 1) ? dat1 : dat0;

    wb_burst_ram_slave #(.AW(AW), .DW(32), .WAIT_STATES(0)) dut0 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_we_i(we),
        .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_dat_o(dat0), .wbs_ack_o(ack0)
    );

    wb_burst_ram_slave #(.AW(AW), .DW(32), .WAIT_STATES(3)) dut1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_we_i(we),
        .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_dat_o(dat1), .wbs_ack_o(ack1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address of beat k from the burst rules, by plain arithmetic.
    function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] s, input logic [2:0] kind,
                                              input logic [1:0] b, input int k);
        int n, base, off;
        if (kind != CTI_INC) return s;
        if (b == BTE_LINEAR) return AW'((int'(s) + k) % DEPTH);
        n    = 2 << b;
        base = int'(s) - (int'(s) % n);
        off  = ((int'(s) % n) + k) % n;
        return AW'(base + off);
    endfunction

    task automatic model_write(input int d, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                mmem[d][a][8*i +: 8] = wd[8*i +: 8];
                mknown[d][a][i]      = 1'b1;
            end
        end
    endtask

    task automatic check_rd(input int d, input logic [AW-1:0] a, input string nm);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{mknown[d][a][i]}};
        if (mask != 32'h0) chk(nm, dat_m & mask, mmem[d][a] & mask);
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (!ack_m && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // One complete cycle/burst on instance d; checks latency, data per beat and ack drop after the last beat.
    task automatic do_burst(input int d, input logic [2:0] kind, input logic [1:0] b, input int n,
                            input bit wr, input logic [AW-1:0] start, input bit rsel,
                            input int gap_at, input int gap_len, input bit use_fix,
                            input logic [31:0] fdat, input logic [3:0] fsel,
                            output logic [31:0] last_rd);
        int cnt;
        bit abort;
        logic [AW-1:0] a;
        abort   = 0;
        last_rd = '0;
        @(posedge clk); #1;
        dsel = d; cyc = 1'b1; we = wr; bte = b;
        for (int k = 0; k < n; k++) begin
            a = exp_adr(start, kind, b, k);
            if (k == gap_at) begin
                stb = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("gap_ack", 32'(ack_m), 32'h0);
                    @(posedge clk); #1;
                end
            end
            adr   = a;
            dat_w = use_fix ? fdat : $urandom;
            sel   = use_fix ? fsel : (rsel ? 4'($urandom) : 4'hF);
            stb   = 1'b1;
            cti   = (k == n - 1) ? ((kind == CTI_CLASSIC) ? CTI_CLASSIC : CTI_EOB) : kind;
            wait_ack(cnt);
            if (!ack_m) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: ack=0 after 40 cycles, required 1 (inst %0d beat %0d adr %h)", d, k, a);
                abort = 1;
                break;
            end
            chk((k == 0) ? "first_lat" : "beat_lat", 32'(cnt), (k == 0) ? 32'(1 + ws[d]) : 32'h0);
            check_rd(d, a, "rd_data");
            if (!wr) last_rd = dat_m;
            else model_write(d, a, dat_w, sel);
            @(posedge clk); #1;
        end
        if (!abort) begin
            cti = CTI_CLASSIC;
            we  = 1'b0;
            @(negedge clk);
            chk("eob_ack_low", 32'(ack_m), 32'h0);
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Wrong address presented after a burst beat: no beat taken, restart via the idle path.
    task automatic miss_test(input int d);
        logic [31:0] v0, rd;
        int cnt;
        v0 = $urandom;
        do_burst(d, CTI_CLASSIC, BTE_LINEAR, 1, 1, 12'h580, 0, -1, 0, 1, v0, 4'hF, rd);
        @(posedge clk); #1;
        dsel = d; cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = BTE_LINEAR; cti = CTI_INC;
        adr = 12'h500; dat_w = $urandom; sel = 4'hF;
        wait_ack(cnt);
        chk("miss_first_lat", 32'(cnt), 32'(1 + ws[d]));
        model_write(d, 12'h500, dat_w, sel);
        @(posedge clk); #1;
        adr = 12'h501; dat_w = $urandom;
        @(negedge clk);
        chk("miss_beat2_ack", 32'(ack_m), 32'h1);
        model_write(d, 12'h501, dat_w, sel);
        @(posedge clk); #1;
        adr = 12'h580; dat_w = $urandom; sel = 4'hF;
        @(posedge clk); #1;
        dat_w = $urandom; sel = 4'b0001; cti = CTI_CLASSIC;
        wait_ack(cnt);
        chk("miss_restart_lat", 32'(cnt), 32'(1 + ws[d]));
        chk("miss_restart_dat", dat_m, v0);
        model_write(d, 12'h580, dat_w, sel);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        do_burst(d, CTI_CLASSIC, BTE_LINEAR, 1, 0, 12'h580, 0, -1, 0, 0, 32'h0, 4'h0, rd);
    endtask

    // Reset asserted while beat 2 of a write burst is on the bus.
    task automatic reset_test;
        logic [31:0] old, rd;
        int cnt;
        old = $urandom | 32'h1;
        do_burst(0, CTI_CLASSIC, BTE_LINEAR, 1, 1, 12'h301, 0, -1, 0, 1, old, 4'hF, rd);
        @(posedge clk); #1;
        dsel = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = BTE_LINEAR; cti = CTI_INC;
        adr = 12'h300; dat_w = $urandom; sel = 4'hF;
        wait_ack(cnt);
        chk("rst_first_lat", 32'(cnt), 32'h1);
        model_write(0, 12'h300, dat_w, sel);
        @(posedge clk); #1;
        adr = 12'h301; dat_w = ~old;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack_m), 32'h0);
        chk("rst_dat", dat0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        do_burst(0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 12'h301, 0, -1, 0, 0, 32'h0, 4'h0, rd);
        chk("rst_no_write", rd, old);
        do_burst(0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 12'h300, 0, -1, 0, 0, 32'h0, 4'h0, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0; cti = '0; bte = '0; dsel = 0;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < DEPTH; a++) begin
                mmem[d][a]   = '0;
                mknown[d][a] = '0;
            end

        vecs[0]  = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{0, 1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0};
        vecs[3]  = '{0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[4]  = '{0, 1'b0, 12'h020, 32'h0,        4'hF, 32'h11BB33DD};
        vecs[5]  = '{0, 1'b1, 12'h020, 32'h55555555, 4'h0, 32'h0};
        vecs[6]  = '{0, 1'b0, 12'h020, 32'h0,        4'hF, 32'h11BB33DD};
        vecs[7]  = '{1, 1'b1, 12'h7FF, 32'h0BADF00D, 4'hF, 32'h0};
        vecs[8]  = '{1, 1'b0, 12'h7FF, 32'h0,        4'hF, 32'h0BADF00D};
        vecs[9]  = '{1, 1'b1, 12'h7FF, 32'hFFFFFFFF, 4'h8, 32'h0};
        vecs[10] = '{1, 1'b0, 12'h7FF, 32'h0,        4'hF, 32'hFFADF00D};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack0", 32'(ack0), 32'h0);
        chk("reset_ack1", 32'(ack1), 32'h0);
        chk("reset_dat0", dat0, 32'h0);
        chk("reset_dat1", dat1, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_burst(vecs[i].d, CTI_CLASSIC, BTE_LINEAR, 1, vecs[i].we, vecs[i].adr, 0, -1, 0,
                     1, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) chk("vec_rd", rd, vecs[i].exp);
        end

        // Wrap-4 read from 6: addresses 6,7,4,5.
        do_burst(0, CTI_INC, BTE_LINEAR, 4, 1, 12'h004, 0, -1, 0, 0, 32'h0, 4'h0, rd);
        do_burst(0, CTI_INC, BTE_WRAP4, 4, 0, 12'h006, 0, -1, 0, 0, 32'h0, 4'h0, rd);

        // Linear burst across the top of memory with wait states, then readback.
        do_burst(1, CTI_INC, BTE_LINEAR, 8, 1, 12'hFFC, 0, -1, 0, 0, 32'h0, 4'h0, rd);
        do_burst(1, CTI_INC, BTE_LINEAR, 8, 0, 12'hFFC, 0, -1, 0, 0, 32'h0, 4'h0, rd);

        // Preload a working region in both instances.
        for (int d = 0; d < 2; d++)
            do_burst(d, CTI_INC, BTE_LINEAR, 64, 1, 12'h400, 0, -1, 0, 0, 32'h0, 4'h0, rd);

        // Strobe gaps mid-burst.
        do_burst(0, CTI_INC, BTE_LINEAR, 6, 0, 12'h400, 0, 2, 2, 0, 32'h0, 4'h0, rd);
        do_burst(1, CTI_INC, BTE_WRAP8, 8, 1, 12'h413, 1, 3, 2, 0, 32'h0, 4'h0, rd);
        do_burst(1, CTI_INC, BTE_WRAP8, 8, 0, 12'h413, 0, 5, 1, 0, 32'h0, 4'h0, rd);

        miss_test(0);
        miss_test(1);
        reset_test();

        for (int it = 0; it < 40; it++) begin
            int d, ks, n, ga, gl;
            logic [2:0] kd;
            logic [1:0] b;
            logic [AW-1:0] st;
            d  = int'($urandom % 2);
            ks = int'($urandom % 3);
            kd = (ks == 0) ? CTI_CLASSIC : ((ks == 1) ? CTI_CONST : CTI_INC);
            b  = 2'($urandom);
            n  = (kd == CTI_CLASSIC) ? 1 : 1 + int'($urandom % 8);
            st = AW'(12'h400 + ($urandom % 64));
            ga = -1;
            gl = 0;
            if (n >= 3 && ($urandom % 3) == 0) begin
                ga = 1 + int'($urandom % (n - 1));
                gl = 1 + int'($urandom % 3);
            end
            do_burst(d, kd, b, n, 1'($urandom), st, 1'($urandom), ga, gl, 0, 32'h0, 4'h0, rd);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
